// File: rtl/vga_sync_gen.sv
// VGA raster timing generator with an internal pixel-rate clock divider.
// Every output is a register loaded from the current h/v counters, one clock behind them.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       hsync,
    output logic       vsync,
    output logic       dValid,
    output logic [9:0] xCor,
    output logic [9:0] yCor,
    output logic       pixTick,
    output logic       frameStart
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_FIRST = H_ACTIVE + H_FP;
    localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FP;
    localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;
    // A divide-by-one build still needs a 1-bit divider that simply stays at 0.
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic SYNC_ACT = (SYNC_POL != 0);

    logic [DIV_W-1:0] div;
    logic [9:0]       h_count;
    logic [9:0]       v_count;
    logic             div_last;
    logic             active;
    logic             hs;
    logic             vs;

    assign div_last = (div == DIV_W'(CLK_DIV - 1));

    always_comb begin
        active = (h_count < 10'(H_ACTIVE)) && (v_count < 10'(V_ACTIVE));
        hs     = (h_count >= 10'(HS_FIRST)) && (h_count <= 10'(HS_LAST));
        vs     = (v_count >= 10'(VS_FIRST)) && (v_count <= 10'(VS_LAST));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div     <= '0;
            h_count <= '0;
            v_count <= '0;
        end else if (div_last) begin
            div <= '0;
            if (h_count == 10'(H_TOTAL - 1)) begin
                h_count <= '0;
                if (v_count == 10'(V_TOTAL - 1))
                    v_count <= '0;
                else
                    v_count <= v_count + 10'd1;
            end else begin
                h_count <= h_count + 10'd1;
            end
        end else begin
            div <= div + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dValid     <= 1'b0;
            xCor       <= '0;
            yCor       <= '0;
            hsync      <= ~SYNC_ACT;
            vsync      <= ~SYNC_ACT;
            pixTick    <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            dValid     <= active;
            xCor       <= active ? h_count : '0;
            yCor       <= active ? v_count : '0;
            hsync      <= hs ? SYNC_ACT : ~SYNC_ACT;
            vsync      <= vs ? SYNC_ACT : ~SYNC_ACT;
            pixTick    <= (div == '0);
            frameStart <= (div == '0) && (h_count == '0) && (v_count == '0);
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: a default 640x480 instance plus two reduced-geometry
// instances (active-high sync with CLK_DIV=2, and CLK_DIV=1) so whole frames fit in a short run.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst_def = 1'b0;
    logic rst_sml = 1'b0;
    logic rst_d1  = 1'b0;

    always #5 clk = ~clk;

    logic       hs_def, vs_def, dv_def, pt_def, fs_def;
    logic [9:0] x_def, y_def;
    logic       hs_sml, vs_sml, dv_sml, pt_sml, fs_sml;
    logic [9:0] x_sml, y_sml;
    logic       hs_d1, vs_d1, dv_d1, pt_d1, fs_d1;
    logic [9:0] x_d1, y_d1;

    int vectors = 0;
    int miscompares = 0;

    vga_sync_gen u_def (
        .clk(clk), .reset_n(rst_def), .hsync(hs_def), .vsync(vs_def), .dValid(dv_def),
        .xCor(x_def), .yCor(y_def), .pixTick(pt_def), .frameStart(fs_def)
    );

    // 15 x 10 raster: hsync on h 10..12, vsync on v 7..8, sync active-high.
    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(2), .SYNC_POL(1)
    ) u_sml (
        .clk(clk), .reset_n(rst_sml), .hsync(hs_sml), .vsync(vs_sml), .dValid(dv_sml),
        .xCor(x_sml), .yCor(y_sml), .pixTick(pt_sml), .frameStart(fs_sml)
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(1), .SYNC_POL(0)
    ) u_d1 (
        .clk(clk), .reset_n(rst_d1), .hsync(hs_d1), .vsync(vs_d1), .dValid(dv_d1),
        .xCor(x_d1), .yCor(y_d1), .pixTick(pt_d1), .frameStart(fs_d1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if ({hs_def, vs_def, dv_def, pt_def, fs_def, x_def, y_def} !== {5'b11000, 20'd0}) begin
                miscompares++;
                $display("FAIL reset_hold clk %0d: got hs=%b vs=%b dv=%b pt=%b fs=%b x=%0d y=%0d, need hs=1 vs=1 dv=0 pt=0 fs=0 x=0 y=0",
                         i, hs_def, vs_def, dv_def, pt_def, fs_def, x_def, y_def);
            end
        end
        vectors++;
        if ({hs_sml, vs_sml, dv_sml, pt_sml, fs_sml} !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_hold_pol1: got hs=%b vs=%b dv=%b pt=%b fs=%b, need all 0",
                     hs_sml, vs_sml, dv_sml, pt_sml, fs_sml);
        end
    endtask

    task automatic test_release();
        @(negedge clk);
        rst_def = 1'b1;
        tick();
        vectors++;
        if ({dv_def, pt_def, fs_def, x_def, y_def} !== {3'b111, 20'd0}) begin
            miscompares++;
            $display("FAIL release_first: got dv=%b pt=%b fs=%b x=%0d y=%0d, need dv=1 pt=1 fs=1 x=0 y=0",
                     dv_def, pt_def, fs_def, x_def, y_def);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            vectors++;
            if ({pt_def, fs_def, x_def} !== {2'b00, 10'd0}) begin
                miscompares++;
                $display("FAIL release_hold clk %0d: got pt=%b fs=%b x=%0d, need pt=0 fs=0 x=0",
                         i, pt_def, fs_def, x_def);
            end
        end
        tick();
        vectors++;
        if ({pt_def, x_def} !== {1'b1, 10'd1}) begin
            miscompares++;
            $display("FAIL release_pixel1: got pt=%b x=%0d, need pt=1 x=1", pt_def, x_def);
        end
    endtask

    // Continues from clock 4 after pixel 0 through the first clock of line 1.
    task automatic test_line_scan();
        int p, ln, shown;
        logic dv, hsx, pt;
        logic [24:0] exp_v;
        shown = 0;
        for (int e = 5; e <= 3200; e++) begin
            tick();
            p   = (e % 3200) / 4;
            ln  = e / 3200;
            dv  = (p < 640);
            hsx = (p >= 656 && p <= 751) ? 1'b0 : 1'b1;
            pt  = ((e % 4) == 0);
            exp_v = {hsx, 1'b1, dv, pt, 1'b0, dv ? 10'(p) : 10'd0, dv ? 10'(ln) : 10'd0};
            vectors++;
            if ({hs_def, vs_def, dv_def, pt_def, fs_def, x_def, y_def} !== exp_v) begin
                miscompares++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL line_scan clk %0d: got {hs,vs,dv,pt,fs,x,y}=%b%b%b%b%b,%0d,%0d need %b,%0d,%0d",
                             e, hs_def, vs_def, dv_def, pt_def, fs_def, x_def, y_def,
                             exp_v[24:20], exp_v[19:10], exp_v[9:0]);
                end
            end
        end
    endtask

    // Two full frames of the reduced CLK_DIV=2 raster (line 30 clocks, frame 300 clocks).
    task automatic test_frame();
        int h, v, shown;
        logic dv, hsx, vsx, pt, fs;
        logic [24:0] exp_v;
        shown = 0;
        @(negedge clk);
        rst_sml = 1'b1;
        for (int e = 0; e <= 600; e++) begin
            tick();
            h   = (e % 30) / 2;
            v   = (e / 30) % 10;
            dv  = (h < 8) && (v < 6);
            hsx = (h >= 10 && h <= 12);
            vsx = (v >= 7 && v <= 8);
            pt  = ((e % 2) == 0);
            fs  = ((e % 300) == 0);
            exp_v = {hsx, vsx, dv, pt, fs, dv ? 10'(h) : 10'd0, dv ? 10'(v) : 10'd0};
            vectors++;
            if ({hs_sml, vs_sml, dv_sml, pt_sml, fs_sml, x_sml, y_sml} !== exp_v) begin
                miscompares++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL frame clk %0d: got {hs,vs,dv,pt,fs,x,y}=%b%b%b%b%b,%0d,%0d need %b,%0d,%0d",
                             e, hs_sml, vs_sml, dv_sml, pt_sml, fs_sml, x_sml, y_sml,
                             exp_v[24:20], exp_v[19:10], exp_v[9:0]);
                end
            end
        end
    endtask

    // Picks up at clock 600 of test_frame; aborts at line 4, pixel 5 of the third frame.
    task automatic test_mid_frame_reset();
        for (int e = 601; e <= 730; e++)
            tick();
        vectors++;
        if ({dv_sml, x_sml, y_sml} !== {1'b1, 10'd5, 10'd4}) begin
            miscompares++;
            $display("FAIL midframe_pos: got dv=%b x=%0d y=%0d, need dv=1 x=5 y=4", dv_sml, x_sml, y_sml);
        end
        rst_sml = 1'b0;
        #1;
        vectors++;
        if ({hs_sml, vs_sml, dv_sml, pt_sml, fs_sml, x_sml, y_sml} !== 25'd0) begin
            miscompares++;
            $display("FAIL midframe_async: got hs=%b vs=%b dv=%b pt=%b fs=%b x=%0d y=%0d, need all 0",
                     hs_sml, vs_sml, dv_sml, pt_sml, fs_sml, x_sml, y_sml);
        end
        tick();
        vectors++;
        if ({hs_sml, vs_sml, dv_sml, pt_sml, fs_sml, x_sml, y_sml} !== 25'd0) begin
            miscompares++;
            $display("FAIL midframe_held: got hs=%b vs=%b dv=%b pt=%b fs=%b x=%0d y=%0d, need all 0",
                     hs_sml, vs_sml, dv_sml, pt_sml, fs_sml, x_sml, y_sml);
        end
        @(negedge clk);
        rst_sml = 1'b1;
        tick();
        vectors++;
        if ({hs_sml, vs_sml, dv_sml, pt_sml, fs_sml, x_sml, y_sml} !== {5'b00111, 20'd0}) begin
            miscompares++;
            $display("FAIL midframe_restart: got hs=%b vs=%b dv=%b pt=%b fs=%b x=%0d y=%0d, need 0 0 1 1 1 0 0",
                     hs_sml, vs_sml, dv_sml, pt_sml, fs_sml, x_sml, y_sml);
        end
        tick();
        vectors++;
        if ({pt_sml, fs_sml, x_sml} !== {2'b00, 10'd0}) begin
            miscompares++;
            $display("FAIL midframe_hold: got pt=%b fs=%b x=%0d, need pt=0 fs=0 x=0", pt_sml, fs_sml, x_sml);
        end
        tick();
        vectors++;
        if ({pt_sml, x_sml} !== {1'b1, 10'd1}) begin
            miscompares++;
            $display("FAIL midframe_pixel1: got pt=%b x=%0d, need pt=1 x=1", pt_sml, x_sml);
        end
    endtask

    // CLK_DIV=1: one pixel per clock, line 15 clocks, frame 150 clocks, active-low sync.
    task automatic test_clk_div1();
        int h, v, shown;
        logic dv, hsx, vsx, fs;
        logic [24:0] exp_v;
        shown = 0;
        @(negedge clk);
        rst_d1 = 1'b1;
        for (int e = 0; e <= 300; e++) begin
            tick();
            h   = e % 15;
            v   = (e / 15) % 10;
            dv  = (h < 8) && (v < 6);
            hsx = (h >= 10 && h <= 12) ? 1'b0 : 1'b1;
            vsx = (v >= 7 && v <= 8) ? 1'b0 : 1'b1;
            fs  = ((e % 150) == 0);
            exp_v = {hsx, vsx, dv, 1'b1, fs, dv ? 10'(h) : 10'd0, dv ? 10'(v) : 10'd0};
            vectors++;
            if ({hs_d1, vs_d1, dv_d1, pt_d1, fs_d1, x_d1, y_d1} !== exp_v) begin
                miscompares++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL clk_div1 clk %0d: got {hs,vs,dv,pt,fs,x,y}=%b%b%b%b%b,%0d,%0d need %b,%0d,%0d",
                             e, hs_d1, vs_d1, dv_d1, pt_d1, fs_d1, x_d1, y_d1,
                             exp_v[24:20], exp_v[19:10], exp_v[9:0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_release();
        test_line_scan();
        test_frame();
        test_mid_frame_reset();
        test_clk_div1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates the VGA raster timing for the display pipeline: horizontal/vertical sync, the active-video qualifier `dValid`, and the pixel coordinates `xCor`/`yCor` consumed by the downstream pattern/colour stage. Runs from the single system clock with an internal pixel-rate divider (default 100 MHz / 4 = 25 MHz, 640x480 @ 60 Hz). It is the source end of the `dValid`/`xCor`/`yCor` interface, and drives `hsync`/`vsync` directly to the connector.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `CLK_DIV`, 4, system clocks per pixel, ≥1
- `SYNC_POL`, 0, sync active level (0 = active-low)
- `clk`  in  1  system clock, all logic rising-edge
- `reset_n`  in  1  asynchronous, active-low reset
- `hsync`  out  1  horizontal sync, active level = `SYNC_POL`
- `vsync`  out  1  vertical sync, active level = `SYNC_POL`
- `dValid`  out  1  high while the current pixel is in the visible area
- `xCor`  out  10  column, 0..H_ACTIVE-1 when `dValid`, else 0
- `yCor`  out  10  row, 0..V_ACTIVE-1 when `dValid`, else 0
- `pixTick`  out  1  one-clock pulse marking the first clock of each new pixel
- `frameStart`  out  1  one-clock pulse on the first clock of pixel (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800), V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525); both ≤1024 (10-bit counters).
- `div` counts 0..CLK_DIV-1, wrapping; with CLK_DIV=1 it stays at 0.
- On any edge where `div`==CLK_DIV-1: `hCount` increments; at H_TOTAL-1 it wraps to 0 and `vCount` increments; `vCount` wraps from V_TOTAL-1 to 0. `hCount` wrapping and `vCount` wrapping on the same edge is the frame wrap to (0,0).
- Decode from current counters (unregistered):
  - active = hCount<H_ACTIVE && vCount<V_ACTIVE
  - hs = hCount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751)
  - vs = vCount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491)
- Output registers, loaded every clock:
  - `dValid` <= active
  - `xCor` <= active ? hCount : 0
  - `yCor` <= active ? vCount : 0
  - `hsync` <= hs ? SYNC_POL : ~SYNC_POL
  - `vsync` <= vs ? SYNC_POL : ~SYNC_POL
  - `pixTick` <= (div==0)
  - `frameStart` <= (div==0 && hCount==0 && vCount==0)
- vsync changes on line boundaries, i.e. together with the hCount 799->0 wrap. There is no hsync/vsync phase offset.
- Reset (asynchronous assert, any time including mid-frame): `div`, `hCount` and `vCount` become 0. `dValid`, `xCor`, `yCor`, `pixTick` and `frameStart` become 0. `hsync` and `vsync` become ~SYNC_POL (inactive). Release restarts the frame from (0,0); no partial-frame recovery.

## Timing
- Outputs lag the counters by exactly one clock; all outputs are glitch-free register outputs.
- First rising edge after `reset_n` deasserts: pixel (0,0) is presented with `dValid`=1, `pixTick`=1 and `frameStart`=1.
- Each pixel value is held for CLK_DIV clocks. `pixTick` is high in the first of those clocks; with CLK_DIV=1 it is constantly high.
- Line period = H_TOTAL·CLK_DIV clocks (3200). Frame period = H_TOTAL·V_TOTAL·CLK_DIV clocks (1,680,000).
- hsync is active for H_SYNC·CLK_DIV clocks (384), starting 656·CLK_DIV clocks after the line's first pixel.
- The downstream consumer registers colour on `pixTick`, or combinationally from `dValid`/`xCor`/`yCor`. Its extra latency is its own concern; this block does not compensate for it.

## Test plan
- Reset hold: `reset_n`=0 for 10 clocks -> `hsync`=`vsync`=1, `dValid`=0, `xCor`=`yCor`=0, `pixTick`=`frameStart`=0 throughout.
- Release: first edge after release -> `dValid`=1, `xCor`=0, `yCor`=0, `pixTick`=1, `frameStart`=1. 4 clocks later -> `xCor`=1, `pixTick`=1; `pixTick`=0 on the 3 clocks between.
- Line scan: `xCor` steps 0..639 each 4 clocks. Next pixel -> `dValid`=0, `xCor`=0. `hsync` falls 2624 clocks after pixel 0, stays low 384 clocks. Next line starts 3200 clocks after pixel 0 with `yCor`=1.
- Frame: `vsync` low exactly during lines 490–491 (6400 clocks). `dValid` never high for `yCor`≥480. `frameStart` pulses are exactly 1,680,000 clocks apart.
- Mid-frame reset: assert `reset_n`=0 at line 300, pixel 400 for 1 clock -> outputs return to reset values immediately (asynchronous). After release, pixel (0,0) with `frameStart`=1 on the first edge.
- CLK_DIV=1 build: `pixTick` constantly 1 after reset, and `frameStart` period is 420,000 clocks.
